// File: rtl/mul_div_pkg.sv
// Shared constants and types for the sequential multiplier / combinational divider pair.
// Widths line up so a divider quotient and divisor can be multiplied back into a dividend.
package mul_div_pkg;

   localparam int DIVIDEND_LEN     = 15;
   localparam int DIVISOR_LEN      = 5;
   localparam int MULTIPLICAND_LEN = 10;
   localparam int MULTIPLIER_LEN   = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int product_width(input int multiplicand_len, input int multiplier_len);
      return multiplicand_len + multiplier_len;
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-and-add unsigned multiplier with a fixed latency of MULTIPLIER_LENGTH
// clock edges from the Start sample to Done.
module seq_multiplier
   import mul_div_pkg::*;
#(
   parameter int MULTIPLICAND_LENGTH = MULTIPLICAND_LEN,
   parameter int MULTIPLIER_LENGTH   = MULTIPLIER_LEN
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           Start,
   input  logic [MULTIPLICAND_LENGTH-1:0]                 OperA,
   input  logic [MULTIPLIER_LENGTH-1:0]                   OperB,
   output logic                                           Busy,
   output logic                                           Done,
   output logic [MULTIPLICAND_LENGTH+MULTIPLIER_LENGTH-1:0] Product
);

   localparam int P  = product_width(MULTIPLICAND_LENGTH, MULTIPLIER_LENGTH);
   // One extra value of headroom so the counter never wraps when N is a power of two.
   localparam int CW = $clog2(MULTIPLIER_LENGTH + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(MULTIPLIER_LENGTH - 1);

   state_t                       state, state_next;
   logic [P-1:0]                 a_reg;
   logic [P-1:0]                 acc_reg;
   logic [P-1:0]                 product_reg;
   logic [MULTIPLIER_LENGTH-1:0] b_reg;
   logic [CW-1:0]                count_reg;

   logic                         start_accept;
   logic                         run_last;
   logic [P-1:0]                 acc_sum;

   assign start_accept = Start && (state != RUN);
   assign run_last     = (state == RUN) && (count_reg == LAST_COUNT);
   assign acc_sum      = acc_reg + (b_reg[0] ? a_reg : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = RUN;
         RUN:     if (run_last) state_next = DONE;
         DONE:    state_next = Start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state == RUN);
      Done = (state == DONE);
   end

   // The last RUN edge stores the sum including its own partial product.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg       <= '0;
         b_reg       <= '0;
         acc_reg     <= '0;
         count_reg   <= '0;
         product_reg <= '0;
      end else if (start_accept) begin
         a_reg     <= P'(OperA);
         b_reg     <= OperB;
         acc_reg   <= '0;
         count_reg <= '0;
      end else if (state == RUN) begin
         acc_reg   <= acc_sum;
         a_reg     <= a_reg << 1;
         b_reg     <= b_reg >> 1;
         count_reg <= count_reg + CW'(1);
         if (run_last) begin
            product_reg <= acc_sum;
         end
      end
   end

   assign Product = product_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench: a cycle-level reference model queues expected products and
// completion cycles; a monitor checks Busy/Done/Product on every falling edge.
module tb_seq_multiplier;

   localparam int N  = 5;
   localparam int AW = 10;
   localparam int P  = 15;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          Start = 1'b0;
   logic [AW-1:0] OperA = '0;
   logic [N-1:0]  OperB = '0;
   logic          Busy;
   logic          Done;
   logic [P-1:0]  Product;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int prod;
      int cyc;
      int a;
      int b;
   } exp_t;

   exp_t q[$];
   int   cycle       = 0;
   int   busy_until  = 0;
   int   free_from   = 0;
   int   last_product = 0;

   seq_multiplier #(
      .MULTIPLICAND_LENGTH(AW),
      .MULTIPLIER_LENGTH  (N)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .Start  (Start),
      .OperA  (OperA),
      .OperB  (OperB),
      .Busy   (Busy),
      .Done   (Done),
      .Product(Product)
   );

   always #5 clk = ~clk;

   // Reference model: an accepted request completes N edges later; the unit is
   // free again one edge after completion.
   always @(posedge clk) begin
      exp_t e;
      cycle = cycle + 1;
      if (rst_n && Start && cycle >= free_from) begin
         e.a    = int'(OperA);
         e.b    = int'(OperB);
         e.prod = e.a * e.b;
         e.cyc  = cycle + N;
         q.push_back(e);
         busy_until = cycle + N;
         free_from  = cycle + N + 1;
         $display("issue    cyc=%0d A=%0d B=%0d expect=%0d at cyc=%0d", cycle, e.a, e.b, e.prod, e.cyc);
      end
   end

   always @(negedge rst_n) begin
      q.delete();
      busy_until   = 0;
      free_from    = 0;
      last_product = 0;
   end

   always @(negedge clk) begin
      logic exp_done;
      logic exp_busy;
      exp_done = (q.size() > 0) && (q[0].cyc == cycle);
      exp_busy = (cycle < busy_until);
      checks++;
      if (Busy !== exp_busy) begin
         errors++;
         $display("FAIL busy cyc=%0d got=%b want=%b", cycle, Busy, exp_busy);
      end
      checks++;
      if (Done !== exp_done) begin
         errors++;
         $display("FAIL done cyc=%0d got=%b want=%b", cycle, Done, exp_done);
      end
      if (exp_done) begin
         last_product = q[0].prod;
         $display("complete cyc=%0d A=%0d B=%0d Product=%0d want=%0d",
                  cycle, q[0].a, q[0].b, Product, q[0].prod);
         void'(q.pop_front());
      end
      checks++;
      if (Product !== P'(last_product)) begin
         errors++;
         $display("FAIL product cyc=%0d got=%0d want=%0d", cycle, Product, last_product);
      end
   end

   // Issue one operation (driver sits on a falling edge), scramble operands
   // while busy, then return on the falling edge where Done is seen.
   task automatic run_op(input int a, input int b);
      int n;
      n = 0;
      while (Busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      Start = 1'b1;
      OperA = AW'(a);
      OperB = N'(b);
      @(negedge clk);
      Start = 1'b0;
      OperA = AW'($urandom);
      OperB = N'($urandom);
      n = 0;
      while (!Done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!Done) begin
         checks++;
         errors++;
         $display("FAIL timeout A=%0d B=%0d got=no_done want=done", a, b);
      end
   endtask

   initial begin
      int dvd[4];
      int dvs[4];
      int gap;
      int n;
      dvd = '{25, 28, 14, 12};
      dvs = '{7, 7, 2, 3};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3, 7);

      for (int i = 0; i < 4; i++) begin
         run_op(dvd[i] / dvs[i], dvs[i]);
         checks++;
         if (int'(Product) + dvd[i] % dvs[i] != dvd[i]) begin
            errors++;
            $display("FAIL roundtrip dividend=%0d got=%0d want=%0d",
                     dvd[i], int'(Product) + dvd[i] % dvs[i], dvd[i]);
         end
      end

      run_op(1023, 31);
      run_op(0, 31);
      run_op(1, 1);
      run_op(1023, 0);

      // Start held high: a new op starts in every DONE cycle.
      Start = 1'b1;
      OperA = 10'd4;
      OperB = 5'd3;
      repeat (20) @(negedge clk);
      Start = 1'b0;

      // Back-to-back: run_op returns in the DONE cycle, next request issued there.
      run_op(5, 5);
      run_op(5, 5);

      // Asynchronous reset in the third RUN cycle.
      n = 0;
      while (Busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      Start = 1'b1;
      OperA = 10'd700;
      OperB = 5'd29;
      @(negedge clk);
      Start = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Product !== '0) begin
         errors++;
         $display("FAIL reset_abort got=busy%b/done%b/%0d want=0/0/0", Busy, Done, Product);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      run_op(9, 9);

      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(0, 1023)), int'($urandom_range(0, 31)));
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(negedge clk);
      end

      n = 0;
      while (q.size() > 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got=%0d pending want=0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
